fixed_add_pipe: RTL and testbench

Parametrised, pipelined two's-complement fixed-point adder with add, subtract, accumulate and load modes, saturation, and overflow reporting. It is the successor to the fixed 16-bit combinational adder, used by the 1D convolution datapath for bias add and partial-sum accumulation. Valid/ready handshake on input and output, with full-pipeline stall on backpressure.

---
 rtl/fixed_add_pipe.sv | 147 ++++++++++++++
 tb/tb_fixed_add_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_add_pipe.sv
// ---------------------------------------------------------------------------
// fixed_add_pipe
//
// Two-stage pipelined two's-complement fixed-point adder with add, subtract,
// accumulate and load modes. It optionally saturates on overflow and reports
// overflow both per beat and as a sticky flag. The binary point does not
// matter here: any Q-format of WIDTH bits passes through unchanged.
//
// Parameters:
//   WIDTH    operand/result width in bits
//   SATURATE 1 = clamp to MAX/MIN on overflow, 0 = wrap modulo 2^WIDTH
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     operand beat valid
//   in_ready     block accepts a beat this cycle
//   op           00 a+b, 01 a-b, 10 acc+a, 11 acc=a
//   a, b         operands (b is ignored for op 10/11)
//   out_valid    result beat valid
//   out_ready    downstream accepts the result
//   result       sum / difference / accumulator value
//   ovf          overflow occurred on this result beat
//   ovf_sticky   OR of every committed overflow since reset or clear
//   clr_sticky   synchronous clear of ovf_sticky; wins over a same-cycle set
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. out_valid/result/ovf stay stable until the
// beat is taken. in_ready is the combinational inverse of the output stall,
// so the whole pipeline, including acc, freezes while the output is blocked.
// Bubbles are not squeezed out.
// ---------------------------------------------------------------------------
module fixed_add_pipe #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             stall;
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   wide;
    logic             wide_ovf;
    logic [WIDTH-1:0] s2_res;
    logic             commit_ovf;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 1: operand capture. s1_valid <= in_valid under ~stall is exactly
    // "a beat was accepted", because in_ready == ~stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_op    <= op;
            s1_a     <= a;
            s1_b     <= b;
        end
    end

    // Stage 2 arithmetic. One guard bit is enough to catch overflow: it shows
    // up as the two top bits of the sign-extended result disagreeing.
    always_comb begin
        a_ext   = {s1_a[WIDTH-1], s1_a};
        b_ext   = {s1_b[WIDTH-1], s1_b};
        acc_ext = {acc[WIDTH-1], acc};
        wide    = a_ext;
        case (s1_op)
            OP_ADD:  wide = a_ext + b_ext;
            OP_SUB:  wide = a_ext - b_ext;
            OP_ACC:  wide = acc_ext + a_ext;
            OP_LOAD: wide = a_ext;
            default: wide = a_ext;
        endcase
        wide_ovf = wide[WIDTH] ^ wide[WIDTH-1];
        if (SATURATE && wide_ovf) begin
            // wide[WIDTH] is the true sign of the unclamped result.
            s2_res = wide[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            s2_res = wide[WIDTH-1:0];
        end
    end

    assign commit_ovf = ~stall & s1_valid & wide_ovf;

    // Stage 2 registers. acc is updated from the clamped value so that a
    // saturated accumulator stays pinned instead of wrapping on later adds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= s2_res;
                ovf    <= wide_ovf;
                if (s1_op[1]) begin
                    acc <= s2_res;
                end
            end
        end
    end

    // Sticky overflow. The clear is applied last so it wins over a set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky | commit_ovf) & ~clr_sticky;
        end
    end

endmodule

// File: tb/tb_fixed_add_pipe.sv
// ---------------------------------------------------------------------------
// Bench for fixed_add_pipe. Two instances share one stimulus stream: one with
// saturation and one that wraps. Each expected entry carries both results.
// Entry packing: {sat_result[15:0], wrap_result[15:0], sat_ovf, wrap_ovf}
// ---------------------------------------------------------------------------
module tb_fixed_add_pipe;

    localparam int W     = 16;
    localparam int EXP_W = 2 * W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         in_valid   = 1'b0;
    logic [1:0]   op         = 2'b00;
    logic [W-1:0] a          = '0;
    logic [W-1:0] b          = '0;
    logic         out_ready  = 1'b1;
    logic         clr_sticky = 1'b0;

    logic         in_ready, out_valid, ovf, ovf_sticky;
    logic [W-1:0] result;
    logic         in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
    logic [W-1:0] result_w;

    fixed_add_pipe #(.WIDTH(W), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky),
        .clr_sticky(clr_sticky)
    );

    fixed_add_pipe #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .op(op), .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w),
        .clr_sticky(clr_sticky)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: looks just after the falling edge, so it sees the handshake
    // values that will be present at the next rising edge.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got result 0x%0h with no beat pending", result);
            end else begin
                e = exp_q.pop_front();
                check("result_sat",  result,      e[2*W+1:W+2]);
                check("result_wrap", result_w,    e[W+1:2]);
                check("ovf_sat",     ovf,         e[1]);
                check("ovf_wrap",    ovf_w,       e[0]);
                check("valid_wrap",  out_valid_w, 1'b1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge. Holds the beat until it is accepted, then
    // returns at the falling edge that follows the accepting rising edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] exp_s,
                        input logic [W-1:0] exp_w, input logic eo_s,
                        input logic eo_w, input bit push);
        int waited = 0;
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waited);
        end else if (push) begin
            exp_q.push_back({exp_s, exp_w, eo_s, eo_w});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #2;
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_in_ready",   in_ready,   1'b1);
        check("rst_result",     result,     16'h0000);
        check("rst_ovf",        ovf,        1'b0);
        check("rst_ovf_sticky", ovf_sticky, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain add with latency probe
        send(2'b00, 16'h34CD, 16'h04CD, 16'h399A, 16'h399A, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        check("lat_early", out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2", out_valid, 1'b1);
        idle(2);

        // Overflow cases
        send(2'b00, 16'h7000, 16'h2000, 16'h7FFF, 16'h9000, 1'b1, 1'b1, 1'b1);
        idle(2);
        check("sticky_set",      ovf_sticky,   1'b1);
        check("sticky_set_wrap", ovf_sticky_w, 1'b1);
        send(2'b01, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(2'b01, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1);
        send(2'b01, 16'h1234, 16'h0234, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        send(2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
        send(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        send(2'b11, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);

        // Back-to-back load/accumulate (b must be ignored)
        send(2'b11, 16'h0100, 16'h5555, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1);
        send(2'b10, 16'h0200, 16'hABCD, 16'h0300, 16'h0300, 1'b0, 1'b0, 1'b1);
        send(2'b10, 16'hFF00, 16'h0000, 16'h0200, 16'h0200, 1'b0, 1'b0, 1'b1);

        // Accumulator saturation vs wrap; op 00 must leave acc alone
        send(2'b11, 16'h7F00, 16'h0000, 16'h7F00, 16'h7F00, 1'b0, 1'b0, 1'b1);
        send(2'b10, 16'h0200, 16'h0000, 16'h7FFF, 16'h8100, 1'b1, 1'b1, 1'b1);
        send(2'b10, 16'h0001, 16'h0000, 16'h7FFF, 16'h8101, 1'b1, 1'b0, 1'b1);
        send(2'b10, 16'hFFFF, 16'h0000, 16'h7FFE, 16'h8100, 1'b0, 1'b0, 1'b1);
        send(2'b00, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1);
        send(2'b10, 16'h0002, 16'h0000, 16'h7FFF, 16'h8102, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain();

        // Clear colliding with an overflow commit: the clear wins
        check("sticky_before_clr", ovf_sticky, 1'b1);
        send(2'b00, 16'h7000, 16'h2000, 16'h7FFF, 16'h9000, 1'b1, 1'b1, 1'b1);
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_clr_wins", ovf_sticky, 1'b0);
        check("ovf_on_clr_beat", ovf,        1'b1);
        @(negedge clk);
        check("sticky_stays_clr", ovf_sticky, 1'b0);
        send(2'b01, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        idle(2);
        check("sticky_reset_again", ovf_sticky, 1'b1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_plain_clr", ovf_sticky, 1'b0);
        drain();

        // Backpressure: three beats, output blocked for 4 cycles after beat 1
        send(2'b00, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1);
        send(2'b00, 16'h0002, 16'h0002, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 2'b00;
        a  = 16'h0003;
        b  = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_in_ready",  in_ready,  1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_result",    result,    16'h0002);
            @(negedge clk);
        end
        out_ready = 1'b1;
        exp_q.push_back({16'h0006, 16'h0006, 1'b0, 1'b0});
        @(negedge clk);
        idle(1);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(2'b00, 16'h7000, 16'h2000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(2'b10, 16'h0009, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_out_valid",  out_valid,  1'b1);
        check("pre_rst_ovf_sticky", ovf_sticky, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid",      out_valid,   1'b0);
        check("mid_rst_out_valid_wrap", out_valid_w, 1'b0);
        check("mid_rst_in_ready",       in_ready,    1'b1);
        check("mid_rst_result",         result,      16'h0000);
        check("mid_rst_ovf",            ovf,         1'b0);
        check("mid_rst_ovf_sticky",     ovf_sticky,  1'b0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        send(2'b10, 16'h0005, 16'h0000, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
        idle(1);
        drain();
        idle(2);

        // final report
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
